// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event queue: protocol bytes,
// parser state encoding and event record layout.
package ps2_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;

    // Bytes following E1 in the Pause make sequence (14 77 E1 F0 14 F0 77).
    localparam int PAUSE_TAIL_LEN = 7;
    localparam int SKIP_W         = 3;

    // Event record is {break, ext, code}.
    localparam int EVT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } parse_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with a registered head word.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             wr_en;
    logic             rd_en;

    assign rd_en       = pop && !empty;
    assign wr_en       = push && (!full || rd_en);
    assign rd_ptr_next = rd_ptr + AW'(rd_en);
    assign count_next  = count + CW'(wr_en) - CW'(rd_en);

    // The head register is preloaded with whatever will sit at rd_ptr next cycle;
    // when the surviving queue is empty, the incoming word becomes the head.
    always_comb begin
        head_next = dout;
        if (count_next != '0) begin
            if (count == CW'(rd_en))
                head_next = din;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            full   <= (count_next == CW'(DEPTH));
            empty  <= (count_next == '0);
            dout   <= head_next;
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser maintaining a 512-bit key-down bitmap and a queued,
// de-duplicated make/break event stream with valid/ready pop.
module ps2_key_event_queue
    import ps2_pkg::*;
#(
    parameter int         FIFO_DEPTH       = 8,
    parameter int         TYPEMATIC_FILTER = 1,
    parameter logic [8:0] PAUSE_CODE       = 9'h1E1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    input  logic                          byte_err,
    input  logic                          event_ready,
    input  logic                          overflow_clr,
    output logic [511:0]                  key_down,
    output logic [8:0]                    event_code,
    output logic                          event_break,
    output logic                          event_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [9:0]                    pressed_count,
    output logic                          any_key,
    output logic                          overflow
);

    parse_state_t      state;
    logic [SKIP_W-1:0] skip_cnt;

    logic              done;
    logic              done_ext;
    logic              done_brk;
    logic [8:0]        done_code;
    logic              pause_done;
    logic              key_bit;
    logic              set_bit;
    logic              clr_bit;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic [EVT_W-1:0]  push_data;
    logic [EVT_W-1:0]  head;
    logic [9:0]        pressed_next;

    // A byte that is not a prefix in the current state completes a key code.
    always_comb begin
        done     = 1'b0;
        done_ext = 1'b0;
        done_brk = 1'b0;
        if (byte_valid && !byte_err) begin
            unique case (state)
                ST_IDLE:    done = !(byte_in inside {BYTE_E0, BYTE_F0, BYTE_E1, BYTE_AA});
                ST_EXT:     begin done = (byte_in != BYTE_E0) && (byte_in != BYTE_F0); done_ext = 1'b1; end
                ST_BRK:     begin done = (byte_in != BYTE_F0); done_brk = 1'b1; end
                ST_EXT_BRK: begin done = (byte_in != BYTE_F0); done_ext = 1'b1; done_brk = 1'b1; end
                default:    ;
            endcase
        end
    end

    assign done_code  = {done_ext, byte_in};
    assign pause_done = byte_valid && !byte_err && (state == ST_PAUSE) && (skip_cnt == SKIP_W'(1));
    assign key_bit    = key_down[done_code];
    assign set_bit    = done && !done_brk && !key_bit;
    assign clr_bit    = done && done_brk && key_bit;
    assign push       = set_bit || clr_bit || pause_done ||
                        (done && !done_brk && key_bit && (TYPEMATIC_FILTER == 0));
    assign push_data  = pause_done ? {1'b0, PAUSE_CODE} : {done_brk, done_code};
    assign pop        = event_valid && event_ready;
    assign drop       = push && fifo_full && !pop;

    assign pressed_next = pressed_count + 10'(set_bit) - 10'(clr_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else if (byte_err) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else if (byte_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (byte_in == BYTE_E0)
                        state <= ST_EXT;
                    else if (byte_in == BYTE_F0)
                        state <= ST_BRK;
                    else if (byte_in == BYTE_E1) begin
                        state    <= ST_PAUSE;
                        skip_cnt <= SKIP_W'(PAUSE_TAIL_LEN);
                    end
                end
                ST_EXT: begin
                    if (byte_in == BYTE_F0)
                        state <= ST_EXT_BRK;
                    else if (byte_in != BYTE_E0)
                        state <= ST_IDLE;
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (byte_in != BYTE_F0)
                        state <= ST_IDLE;
                end
                ST_PAUSE: begin
                    skip_cnt <= skip_cnt - 1'b1;
                    if (skip_cnt == SKIP_W'(1))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_down      <= '0;
            pressed_count <= '0;
            any_key       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (set_bit)
                key_down[done_code] <= 1'b1;
            if (clr_bit)
                key_down[done_code] <= 1'b0;
            pressed_count <= pressed_next;
            any_key       <= (pressed_next != '0);
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign event_valid = !fifo_empty;
    assign event_code  = head[8:0];
    assign event_break = head[9];

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed scenarios followed by random byte traffic,
// all checked against a queue/bitmap reference model.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     byte_in = '0;
    logic           byte_valid = 1'b0;
    logic           byte_err = 1'b0;
    logic           event_ready = 1'b0;
    logic           overflow_clr = 1'b0;
    logic [511:0]   key_down;
    logic [8:0]     event_code;
    logic           event_break;
    logic           event_valid;
    logic [CW-1:0]  fifo_count;
    logic [9:0]     pressed_count;
    logic           any_key;
    logic           overflow;

    // Second instance without the typematic filter, never popped.
    logic [511:0]   nf_key_down;
    logic [8:0]     nf_event_code;
    logic           nf_event_break;
    logic           nf_event_valid;
    logic [CW-1:0]  nf_fifo_count;
    logic [9:0]     nf_pressed_count;
    logic           nf_any_key;
    logic           nf_overflow;

    always #5 clk = ~clk;

    ps2_key_event_queue #(.FIFO_DEPTH(DEPTH), .TYPEMATIC_FILTER(1), .PAUSE_CODE(9'h1E1)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_err(byte_err),
        .event_ready(event_ready), .overflow_clr(overflow_clr), .key_down(key_down),
        .event_code(event_code), .event_break(event_break), .event_valid(event_valid),
        .fifo_count(fifo_count), .pressed_count(pressed_count), .any_key(any_key),
        .overflow(overflow)
    );

    ps2_key_event_queue #(.FIFO_DEPTH(DEPTH), .TYPEMATIC_FILTER(0), .PAUSE_CODE(9'h1E1)) dut_nf (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_err(byte_err),
        .event_ready(1'b0), .overflow_clr(1'b0), .key_down(nf_key_down),
        .event_code(nf_event_code), .event_break(nf_event_break), .event_valid(nf_event_valid),
        .fifo_count(nf_fifo_count), .pressed_count(nf_pressed_count), .any_key(nf_any_key),
        .overflow(nf_overflow)
    );

    // Reference model: held keys, pending events {break, code}, prefix flags.
    bit [511:0]  m_keys;
    logic [9:0]  m_q[$];
    bit          m_ovf;
    bit          m_ext;
    bit          m_brk;
    int          m_pause;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcnt(input bit [511:0] v);
        int c = 0;
        for (int i = 0; i < 512; i++) c += v[i];
        return c;
    endfunction

    task automatic m_clear();
        m_keys = '0; m_q.delete(); m_ovf = 0; m_ext = 0; m_brk = 0; m_pause = 0;
    endtask

    task automatic m_push(input logic [9:0] e);
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_ovf = 1;
    endtask

    task automatic m_complete(input bit ext, input bit brk, input logic [7:0] b);
        logic [8:0] idx;
        idx = {ext, b};
        if (!brk) begin
            if (!m_keys[idx]) begin m_keys[idx] = 1; m_push({1'b0, idx}); end
        end else if (m_keys[idx]) begin
            m_keys[idx] = 0; m_push({1'b1, idx});
        end
        m_ext = 0; m_brk = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) m_push({1'b0, 9'h1E1});
        end else if (!m_ext && !m_brk) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE1) m_pause = 7;
            else if (b != 8'hAA) m_complete(0, 0, b);
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0 && m_ext && !m_brk) begin
            m_ext = 1;
        end else begin
            m_complete(m_ext, m_brk, b);
        end
    endtask

    task automatic check_all();
        check("key_down", key_down, m_keys);
        check("pressed_count", pressed_count, popcnt(m_keys));
        check("any_key", any_key, m_keys != '0);
        check("fifo_count", fifo_count, m_q.size());
        check("event_valid", event_valid, m_q.size() > 0);
        check("overflow", overflow, m_ovf);
        if (m_q.size() > 0) begin
            check("event_code", event_code, m_q[0][8:0]);
            check("event_break", event_break, m_q[0][9]);
        end
    endtask

    // One clock of stimulus, applied between falling edges.
    task automatic step(input bit v, input logic [7:0] b, input bit err, input bit rdy, input bit clr);
        byte_in = b; byte_valid = v; byte_err = err; event_ready = rdy; overflow_clr = clr;
        @(negedge clk);
        byte_valid = 0; byte_err = 0; event_ready = 0; overflow_clr = 0;
        if (clr) m_ovf = 0;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (err) begin
            m_ext = 0; m_brk = 0; m_pause = 0;
        end else if (v) begin
            m_byte(b);
        end
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && m_q.size() > 0; i++) step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        m_clear();
        check_all();
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'h1C, 8'h1B,
                              8'h23, 8'h2B, 8'h75, 8'h6B, 8'h74, 8'h72, 8'h14, 8'h77};
    logic [7:0] makes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_clear();
        do_reset();

        // Plain make/break with pops after each.
        send(8'h1C);
        check("make_1c_bit", key_down[9'h01C], 1'b1);
        check("make_1c_code", {event_break, event_code}, 10'h01C);
        drain();
        send(8'hF0); send(8'h1C);
        check("brk_1c_bit", key_down[9'h01C], 1'b0);
        check("brk_1c_code", {event_break, event_code}, 10'h21C);
        drain();

        // Extended make/break.
        send(8'hE0); send(8'h75);
        check("make_175_bit", key_down[9'h175], 1'b1);
        drain();
        send(8'hE0); send(8'hF0); send(8'h75);
        check("brk_175_code", {event_break, event_code}, 10'h375);
        drain();

        // Typematic repeats: filtered vs unfiltered instance.
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("typ_filter_count", fifo_count, 1);
        check("typ_nofilter_count", nf_fifo_count, 3);
        check("typ_nofilter_pressed", nf_pressed_count, 1);
        check("typ_nofilter_head", {nf_event_valid, nf_event_break, nf_event_code}, 11'h41C);
        drain();

        // Overflow with ten distinct makes.
        do_reset();
        for (int i = 0; i < 10; i++) send(makes[i]);
        check("ovf_count", fifo_count, 8);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_pressed", pressed_count, 10);
        drain();
        step(0, 8'h00, 0, 0, 1);
        check("ovf_clr", overflow, 1'b0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) send(makes[i]);
        step(1, makes[8], 0, 1, 0);
        check("bypass_count", fifo_count, 8);
        check("bypass_ovf", overflow, 1'b0);
        drain();

        // Pause sequence then a normal key.
        do_reset();
        for (int i = 0; i < 8; i++) send(pause_seq[i]);
        check("pause_count", fifo_count, 1);
        check("pause_code", {event_break, event_code}, 10'h1E1);
        check("pause_keys", key_down, '0);
        send(8'h1C);
        drain();

        // Error discards a pending break prefix; AA at idle is ignored.
        do_reset();
        send(8'h1C); drain();
        send(8'hF0);
        step(0, 8'h00, 1, 0, 0);
        send(8'h1C);
        check("err_no_break", key_down[9'h01C], 1'b1);
        send(8'hAA);
        check("aa_ignored", fifo_count, 0);

        // Asynchronous reset in the middle of an E0 prefix.
        send(8'h23);
        send(8'hE0);
        #2 rst = 1;
        #2;
        m_clear();
        check("rst_keys", key_down, '0);
        check("rst_valid", event_valid, 1'b0);
        check("rst_code", {event_break, event_code}, 10'h000);
        @(negedge clk);
        rst = 0;
        check_all();
        send(8'h75);
        check("rst_prefix_gone", {event_break, event_code}, 10'h075);
        drain();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1, pool[$urandom_range(15)], ($urandom_range(39) == 0),
                 ($urandom_range(2) == 0), ($urandom_range(19) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
